// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus for mem_port_arbiter: one outstanding transaction with
// a req/gnt/rvalid handshake.
//   req    master -> arbiter  request, held with payload until gnt
//   we     master -> arbiter  byte write enables, all-zero means read
//   addr   master -> arbiter  address
//   wdata  master -> arbiter  write data
//   gnt    arbiter -> master  one-cycle pulse, command issued to memory
//   rvalid arbiter -> master  one-cycle pulse, rdata valid
//   rdata  arbiter -> master  read data, held until the next read response
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic [DATA_W/8-1:0]   we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory between the multicycle CPU
// (port c) and a second master such as an accelerator or DMA (port a).
// One transaction is in flight at a time: IDLE -> ISSUE -> IDLE for writes,
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE for reads.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   c, a     requester buses (slave side of mem_port_arbiter_if)
//   m_en     memory command strobe
//   m_we     memory byte enables, zero whenever m_en is low
//   m_addr   memory address
//   m_wdata  memory write data
//   m_rdata  memory read data, valid RD_LAT cycles after m_en
//   busy     high whenever a transaction is in progress
// ARB_MODE 0 alternates between ports under contention; ARB_MODE 1 gives
// the CPU absolute priority (port a may starve).
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   c,
    mem_port_arbiter_if.slave   a,
    output logic                m_en,
    output logic [DATA_W/8-1:0] m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [2:0]  LAT  = 3'(RD_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                id_q, id_d;       // owner of current transaction: 0 = c, 1 = a
    logic                last_q, last_d;   // port granted most recently: 0 = c, 1 = a
    logic [BE_W-1:0]     we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic                pick_a;

    // Winner when arbitrating in IDLE; only meaningful if some req is set.
    always_comb begin
        if (ARB_MODE == 1)
            pick_a = !c.req;
        else
            pick_a = a.req && (!c.req || !last_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            c_rdata_q <= '0;
            a_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            c_rdata_q <= c_rdata_d;
            a_rdata_q <= a_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        c_rdata_d = c_rdata_q;
        a_rdata_d = a_rdata_q;
        case (state_q)
            IDLE: begin
                if (c.req || a.req) begin
                    id_d    = pick_a;
                    last_d  = pick_a;
                    we_d    = pick_a ? a.we    : c.we;
                    addr_d  = pick_a ? a.addr  : c.addr;
                    wdata_d = pick_a ? a.wdata : c.wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q != '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = LAT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Last wait cycle: memory data is valid now.
                if (cnt_q == 3'd1) begin
                    if (id_q) a_rdata_d = m_rdata;
                    else      c_rdata_d = m_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign m_en     = (state_q == ISSUE);
    assign m_we     = m_en ? we_q    : '0;
    assign m_addr   = m_en ? addr_q  : '0;
    assign m_wdata  = m_en ? wdata_q : '0;
    assign c.gnt    = m_en && !id_q;
    assign a.gnt    = m_en &&  id_q;
    assign c.rvalid = (state_q == RESP) && !id_q;
    assign a.rvalid = (state_q == RESP) &&  id_q;
    assign c.rdata  = c_rdata_q;
    assign a.rdata  = a_rdata_q;
    assign busy     = (state_q != IDLE);
endmodule
